pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised fetch-PC generator for the pipelined MIPS core. Replaces the purely combinational next-PC selection with a registered PC.
- Adds stall/redirect handshaking, a configurable reset vector and instruction-memory base, and target range/alignment checking with a sticky halt state.
- Sits at the IF stage. Consumes redirect requests resolved in a later stage. Drives the absolute PC and the word index into instruction memory.

Parameters:
- ADDR_W, 32, PC width; must be ≥ IM_AW+2 and ≥ 28+4 for j-type composition.
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- IM_BASE, 32'h0000_3000, byte address of instruction memory word 0.
- IM_AW, 12, instruction memory word-address width (depth = 2^IM_AW words).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hold PC (IF stall).
- redir_valid_i  in  1  redirect request this cycle.
- redir_sel_i  in  2  1=branch, 2=jump (j/jal), 3=jr; 0=no-op even if valid.
- redir_pc_i  in  ADDR_W  PC of the redirecting instruction.
- offset16_i  in  16  branch immediate.
- index26_i  in  26  j-type instr_index.
- jr_target_i  in  ADDR_W  register target for jr.
- pc_o  out  ADDR_W  current fetch PC.
- pc_plus4_o  out  ADDR_W  pc_o+4.
- im_addr_o  out  IM_AW  (pc_o-IM_BASE)>>2, truncated to IM_AW bits.
- fetch_valid_o  out  1  pc_o is a real fetch.
- fault_o  out  1  sticky target fault.

Behaviour:
- Target arithmetic (combinational, modulo 2^ADDR_W):
  - sel=1: redir_pc_i + 4 + sext({offset16_i,2'b00}).
  - sel=2: {(redir_pc_i+4)[ADDR_W-1:28], index26_i, 2'b00}.
  - sel=3: jr_target_i.
- Target is illegal if tgt[1:0]!=0, or if unsigned (tgt-IM_BASE) >= 4·2^IM_AW.
- FSM has three states: BOOT, RUN, HALT.
- Reset (async, any time): state=BOOT, pc_o=RESET_PC, fetch_valid_o=0, fault_o=0.
- BOOT: one cycle. fetch_valid_o=0, PC unchanged, then RUN. Stall and redirect are ignored in BOOT.
- RUN: fetch_valid_o=1. Per edge, in priority order:
  1. redir_valid_i && sel!=0 && legal target → pc ← target. Redirect overrides stall_i.
  2. redir_valid_i && sel!=0 && illegal target → state ← HALT, fault_o ← 1, pc unchanged.
  3. stall_i → pc held.
  4. Otherwise → pc ← pc+4.
- HALT: pc frozen, fetch_valid_o=0, fault_o=1. Only rst_n exits HALT.
- Sequential pc+4 past the IM end is not a fault. pc wraps modulo 2^ADDR_W; im_addr_o wraps modulo 2^IM_AW.
- Latency: a redirect sampled on edge N is visible on pc_o after edge N. No bubble is inserted by this block; the pipeline owns flushing.
- pc_plus4_o and im_addr_o are combinational from the pc register.

Optional Feature:
- Macro: PC_GEN_EXC_EN.
- When defined:
  - Adds parameter EXC_VEC (default 32'h0000_4180).
  - Adds ports: exc_i (in 1), eret_i (in 1), epc_o (out ADDR_W).
  - Adds an EPC register, reset value 0.
- Exception behaviour in RUN:
  - exc_i=1 → EPC ← pc_o, pc ← EXC_VEC.
  - exc_i has priority over redirect, eret and stall.
- Illegal redirect target with the feature: EPC ← redir_pc_i, pc ← EXC_VEC, fault_o pulses high for 1 cycle, and the FSM stays in RUN. HALT is unreachable.
- eret_i=1 (and exc_i=0) → pc ← EPC. eret has priority over redirect.
- When undefined: none of these ports exist, and behaviour is exactly as above.

Test Plan:
- Reset release, no stall, default parameters → BOOT cycle with pc_o=0x3000 and fetch_valid_o=0. Then pc_o=0x3000, 0x3004, 0x3008; im_addr_o=0, 1, 2.
- Branch, redir_pc_i=0x3010, offset16_i=0xFFFC, with stall_i=1 in the same cycle → next pc_o=0x3004 (redirect beats stall).
- Jump, redir_pc_i=0x3020, index26_i=0x0000C10 → pc_o=0x3040. Then jr with jr_target_i=0x3100 → pc_o=0x3100, im_addr_o=0x40.
- jr with jr_target_i=0x3102 → fault_o=1, fetch_valid_o=0, pc_o holds. Further redirects are ignored. Assert rst_n=0 mid-HALT → immediate pc_o=0x3000, fault_o=0.
- Out-of-range jr target 0x7000 (IM_AW=12), and IM_AW=4 with sequential fetch past 0x303C → first case faults; second case shows no fault and im_addr_o wrapping to 0.
- PC_GEN_EXC_EN defined: exc_i at pc_o=0x3008 → epc_o=0x3008, pc_o=0x4180. Then eret_i → pc_o=0x3008. Illegal jr target → pc_o=0x4180 with a one-cycle fault_o pulse.

Source files
------------

// File: rtl/pc_gen.sv
// Registered fetch-PC generator for the IF stage: BOOT/RUN/HALT sequencing, redirect target checking.
// Optional exception/eret support (EPC register, EXC_VEC entry) is enabled by defining PC_GEN_EXC_EN.
module pc_gen #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000,
    parameter logic [ADDR_W-1:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned       IM_AW    = 12
`ifdef PC_GEN_EXC_EN
    ,
    parameter logic [ADDR_W-1:0] EXC_VEC  = 32'h0000_4180
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redir_valid_i,
    input  logic [1:0]        redir_sel_i,
    input  logic [ADDR_W-1:0] redir_pc_i,
    input  logic [15:0]       offset16_i,
    input  logic [25:0]       index26_i,
    input  logic [ADDR_W-1:0] jr_target_i,
`ifdef PC_GEN_EXC_EN
    input  logic              exc_i,
    input  logic              eret_i,
    output logic [ADDR_W-1:0] epc_o,
`endif
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic [IM_AW-1:0]  im_addr_o,
    output logic              fetch_valid_o,
    output logic              fault_o
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    // Byte span of instruction memory, one bit wider so the compare never overflows.
    localparam logic [ADDR_W:0] IM_SPAN = (ADDR_W+1)'(1) << (IM_AW + 2);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_fetch_valid;
    logic              r_fault;
    logic [ADDR_W-1:0] w_redir_pc4;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_tgt_off;
    logic              w_tgt_illegal;
    logic              w_redir;
    logic [ADDR_W-1:0] w_pc_plus4;
`ifdef PC_GEN_EXC_EN
    logic [ADDR_W-1:0] r_epc;
`endif

    assign w_redir_pc4 = redir_pc_i + ADDR_W'(4);
    assign w_br_off    = {{(ADDR_W-18){offset16_i[15]}}, offset16_i, 2'b00};
    assign w_redir     = redir_valid_i && (redir_sel_i != 2'd0);
    assign w_pc_plus4  = r_pc + ADDR_W'(4);

    always_comb begin
        w_target = '0;
        case (redir_sel_i)
            2'd1:    w_target = w_redir_pc4 + w_br_off;
            2'd2:    w_target = {w_redir_pc4[ADDR_W-1:28], index26_i, 2'b00};
            2'd3:    w_target = jr_target_i;
            default: w_target = '0;
        endcase
    end

    // Targets below IM_BASE wrap to large offsets and fail the same range check.
    assign w_tgt_off     = w_target - IM_BASE;
    assign w_tgt_illegal = (w_target[1:0] != 2'b00) || ({1'b0, w_tgt_off} >= IM_SPAN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_fault       <= 1'b0;
`ifdef PC_GEN_EXC_EN
            r_epc         <= '0;
`endif
        end else begin
            case (r_state)
                BOOT: begin
                    r_state       <= RUN;
                    r_fetch_valid <= 1'b1;
                end
                RUN: begin
`ifdef PC_GEN_EXC_EN
                    r_fault <= 1'b0;
                    if (exc_i) begin
                        r_epc <= r_pc;
                        r_pc  <= EXC_VEC;
                    end else if (eret_i) begin
                        r_pc <= r_epc;
                    end else if (w_redir && !w_tgt_illegal) begin
                        r_pc <= w_target;
                    end else if (w_redir) begin
                        // Bad target becomes an exception; fault_o is a one-cycle pulse.
                        r_epc   <= redir_pc_i;
                        r_pc    <= EXC_VEC;
                        r_fault <= 1'b1;
                    end else if (!stall_i) begin
                        r_pc <= w_pc_plus4;
                    end
`else
                    if (w_redir && !w_tgt_illegal) begin
                        r_pc <= w_target;
                    end else if (w_redir) begin
                        r_state       <= HALT;
                        r_fault       <= 1'b1;
                        r_fetch_valid <= 1'b0;
                    end else if (!stall_i) begin
                        r_pc <= w_pc_plus4;
                    end
`endif
                end
                HALT: begin
                    r_fetch_valid <= 1'b0;
                    r_fault       <= 1'b1;
                end
                default: begin
                    r_state <= HALT;
                end
            endcase
        end
    end

    assign pc_o          = r_pc;
    assign pc_plus4_o    = w_pc_plus4;
    assign im_addr_o     = IM_AW'((r_pc - IM_BASE) >> 2);
    assign fetch_valid_o = r_fetch_valid;
    assign fault_o       = r_fault;
`ifdef PC_GEN_EXC_EN
    assign epc_o         = r_epc;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: behavioural next-PC model checked every cycle plus directed literal checks.
// A second instance with IM_AW=4 covers sequential fetch wrapping past the end of instruction memory.
module tb_pc_gen;

    localparam logic [31:0] BASE = 32'h0000_3000;
    localparam logic [31:0] EXCV = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redir_valid_i;
    logic [1:0]  redir_sel_i;
    logic [31:0] redir_pc_i;
    logic [15:0] offset16_i;
    logic [25:0] index26_i;
    logic [31:0] jr_target_i;
    logic [31:0] pc_o, pc_plus4_o;
    logic [11:0] im_addr_o;
    logic        fetch_valid_o, fault_o;
    logic [31:0] s_pc, s_pc4;
    logic [3:0]  s_im;
    logic        s_fv, s_fault;
`ifdef PC_GEN_EXC_EN
    logic        exc_i, eret_i;
    logic [31:0] epc_o, s_epc;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(32), .RESET_PC(32'h0000_3000), .IM_BASE(32'h0000_3000), .IM_AW(12)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redir_valid_i(redir_valid_i),
        .redir_sel_i(redir_sel_i), .redir_pc_i(redir_pc_i), .offset16_i(offset16_i),
        .index26_i(index26_i), .jr_target_i(jr_target_i),
`ifdef PC_GEN_EXC_EN
        .exc_i(exc_i), .eret_i(eret_i), .epc_o(epc_o),
`endif
        .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .im_addr_o(im_addr_o),
        .fetch_valid_o(fetch_valid_o), .fault_o(fault_o)
    );

    pc_gen #(.IM_AW(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .stall_i(1'b0), .redir_valid_i(1'b0),
        .redir_sel_i(2'd0), .redir_pc_i(32'h0), .offset16_i(16'h0),
        .index26_i(26'h0), .jr_target_i(32'h0),
`ifdef PC_GEN_EXC_EN
        .exc_i(1'b0), .eret_i(1'b0), .epc_o(s_epc),
`endif
        .pc_o(s_pc), .pc_plus4_o(s_pc4), .im_addr_o(s_im),
        .fetch_valid_o(s_fv), .fault_o(s_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] f_tgt(input logic [1:0] s, input logic [31:0] rpc,
                                          input logic [15:0] off, input logic [25:0] idx,
                                          input logic [31:0] jr);
        logic [31:0] seq;
        seq = rpc + 32'd4;
        case (s)
            2'd1:    return seq + (32'($signed(off)) << 2);
            2'd2:    return (seq & 32'hF000_0000) | (32'(idx) << 2);
            2'd3:    return jr;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit f_legal(input logic [31:0] t);
        return ((t & 32'd3) == 32'd0) && ((t - BASE) < 32'h0000_4000);
    endfunction

    int          m_phase;   // 0 boot, 1 run, 2 halted
    logic [31:0] m_pc, m_epc, m_t;
    logic        m_fault;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_pc = BASE; m_fault = 1'b0; m_epc = 32'h0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_t = f_tgt(redir_sel_i, redir_pc_i, offset16_i, index26_i, jr_target_i);
            m_fault = 1'b0;
`ifdef PC_GEN_EXC_EN
            if (exc_i) begin m_epc = m_pc; m_pc = EXCV; end
            else if (eret_i) m_pc = m_epc;
            else if (redir_valid_i && redir_sel_i != 2'd0) begin
                if (f_legal(m_t)) m_pc = m_t;
                else begin m_epc = redir_pc_i; m_pc = EXCV; m_fault = 1'b1; end
            end else if (!stall_i) m_pc = m_pc + 32'd4;
`else
            if (redir_valid_i && redir_sel_i != 2'd0) begin
                if (f_legal(m_t)) m_pc = m_t;
                else begin m_phase = 2; m_fault = 1'b1; end
            end else if (!stall_i) m_pc = m_pc + 32'd4;
`endif
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_pc", pc_o, m_pc);
            chk("m_pc4", pc_plus4_o, m_pc + 32'd4);
            chk("m_im", 32'(im_addr_o), ((m_pc - BASE) >> 2) & 32'hFFF);
            chk("m_fv", 32'(fetch_valid_o), (m_phase == 1) ? 32'd1 : 32'd0);
            chk("m_fault", 32'(fault_o), 32'(m_fault));
`ifdef PC_GEN_EXC_EN
            chk("m_epc", epc_o, m_epc);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [1:0] s, input logic [31:0] rpc, input logic [15:0] off,
                         input logic [25:0] idx, input logic [31:0] jr);
        redir_valid_i = 1'b1; redir_sel_i = s; redir_pc_i = rpc;
        offset16_i = off; index26_i = idx; jr_target_i = jr;
    endtask

    task automatic idle();
        redir_valid_i = 1'b0; redir_sel_i = 2'd0;
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; idle();
        redir_pc_i = '0; offset16_i = '0; index26_i = '0; jr_target_i = '0;
`ifdef PC_GEN_EXC_EN
        exc_i = 1'b0; eret_i = 1'b0;
`endif
        repeat (2) tick();
        chk("rst_pc", pc_o, 32'h3000);
        chk("rst_fault", 32'(fault_o), 32'd0);
        rst_n = 1'b1;
        chk("boot_pc", pc_o, 32'h3000);
        chk("boot_fv", 32'(fetch_valid_o), 32'd0);
        tick(); chk("run0_pc", pc_o, 32'h3000); chk("run0_im", 32'(im_addr_o), 32'd0);
        chk("run0_fv", 32'(fetch_valid_o), 32'd1);
        tick(); chk("run1_pc", pc_o, 32'h3004); chk("run1_im", 32'(im_addr_o), 32'd1);
        tick(); chk("run2_pc", pc_o, 32'h3008); chk("run2_im", 32'(im_addr_o), 32'd2);

        redir(2'd1, 32'h3010, 16'hFFFC, 26'h0, 32'h0); stall_i = 1'b1;
        tick(); chk("br_beats_stall", pc_o, 32'h3004);
        stall_i = 1'b0;
        redir(2'd2, 32'h3020, 16'h0, 26'h0000C10, 32'h0);
        tick(); chk("jump_pc", pc_o, 32'h3040);
        redir(2'd3, 32'h0, 16'h0, 26'h0, 32'h3100);
        tick(); chk("jr_pc", pc_o, 32'h3100); chk("jr_im", 32'(im_addr_o), 32'h40);
        idle(); stall_i = 1'b1;
        tick(); chk("stall_pc", pc_o, 32'h3100);
        stall_i = 1'b0;
        tick(); chk("after_stall_pc", pc_o, 32'h3104);

`ifndef PC_GEN_EXC_EN
        redir(2'd3, 32'h0, 16'h0, 26'h0, 32'h3102);
        tick(); chk("misalign_fault", 32'(fault_o), 32'd1);
        chk("misalign_fv", 32'(fetch_valid_o), 32'd0); chk("misalign_pc", pc_o, 32'h3104);
        redir(2'd3, 32'h0, 16'h0, 26'h0, 32'h3100);
        tick(); chk("halt_ignore_pc", pc_o, 32'h3104); chk("halt_fault", 32'(fault_o), 32'd1);
        idle();
        #2 rst_n = 1'b0;
        #1 chk("async_rst_pc", pc_o, 32'h3000); chk("async_rst_fault", 32'(fault_o), 32'd0);
        tick(); rst_n = 1'b1;
        tick(); chk("reboot_pc", pc_o, 32'h3000); chk("reboot_fv", 32'(fetch_valid_o), 32'd1);
        redir(2'd3, 32'h0, 16'h0, 26'h0, 32'h6FFC);
        tick(); chk("last_word_pc", pc_o, 32'h6FFC); chk("last_word_im", 32'(im_addr_o), 32'hFFF);
        idle();
        tick(); chk("seq_past_end_pc", pc_o, 32'h7000); chk("seq_past_end_fault", 32'(fault_o), 32'd0);
        chk("seq_past_end_im", 32'(im_addr_o), 32'd0);
        redir(2'd3, 32'h0, 16'h0, 26'h0, 32'h7000);
        tick(); chk("oor_fault", 32'(fault_o), 32'd1); chk("oor_pc", pc_o, 32'h7000);
        idle();
`else
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        tick(); tick(); tick(); chk("exc_pre_pc", pc_o, 32'h3008);
        exc_i = 1'b1;
        tick(); chk("exc_pc", pc_o, 32'h4180); chk("exc_epc", epc_o, 32'h3008);
        exc_i = 1'b0; eret_i = 1'b1;
        tick(); chk("eret_pc", pc_o, 32'h3008);
        eret_i = 1'b0;
        redir(2'd3, 32'h3010, 16'h0, 26'h0, 32'h3102);
        tick(); chk("bad_tgt_pc", pc_o, 32'h4180); chk("bad_tgt_fault", 32'(fault_o), 32'd1);
        chk("bad_tgt_epc", epc_o, 32'h3010); chk("bad_tgt_fv", 32'(fetch_valid_o), 32'd1);
        idle();
        tick(); chk("pulse_end_fault", 32'(fault_o), 32'd0); chk("pulse_end_pc", pc_o, 32'h4184);
`endif

        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int k = 0; k < 40 && s_pc !== 32'h303C; k++) tick();
        chk("small_reach_end", s_pc, 32'h303C);
        chk("small_end_im", 32'(s_im), 32'hF);
        tick();
        chk("small_wrap_pc", s_pc, 32'h3040); chk("small_wrap_im", 32'(s_im), 32'd0);
        chk("small_wrap_fault", 32'(s_fault), 32'd0); chk("small_wrap_fv", 32'(s_fv), 32'd1);
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
